// File: rtl/sram_dma_engine.sv
// sram_dma_engine: request-side bulk memory engine for the single-port SRAM
// controller. Performs ascending word copy, pattern fill and pattern check
// over the SRAM, one job per start pulse, ending in a one-cycle done pulse.
module sram_dma_engine #(
   parameter int AW = 13,
   parameter int DW = 32,
   parameter int LW = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [1:0]    i_mode,
   input  logic [AW-1:0] i_src_addr,
   input  logic [AW-1:0] i_dst_addr,
   input  logic [LW-1:0] i_len_words,
   input  logic [DW-1:0] i_pattern,
   input  logic          i_abort,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [AW-1:0] o_err_addr,
   output logic [LW-1:0] o_words_done,
   output logic          o_sram_req,
   output logic          o_sram_we,
   output logic [3:0]    o_sram_be,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_wdata,
   input  logic [DW-1:0] i_sram_rdata,
   input  logic          i_sram_ready
);

   localparam logic [1:0]    MODE_COPY  = 2'b00;
   localparam logic [1:0]    MODE_FILL  = 2'b01;
   localparam logic [1:0]    MODE_CHECK = 2'b10;
   localparam logic [1:0]    MODE_RSVD  = 2'b11;
   localparam logic [AW-1:0] WORD_STEP  = AW'(4);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_DONE
   } state_t;

   state_t        r_state;
   logic [1:0]    r_mode;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [LW-1:0] r_len;
   logic [DW-1:0] r_pattern;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [AW-1:0] r_err_addr;
   logic [LW-1:0] r_words;
   logic          r_req;
   logic          r_we;
   logic [3:0]    r_be;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   logic          w_accept;
   logic          w_active;
   logic [LW-1:0] w_words_inc;
   logic          w_last;
   logic [AW-1:0] w_dst_next;
   logic [AW-1:0] w_src_next;
   logic          w_finish;

   assign w_accept    = r_req & i_sram_ready;
   assign w_active    = (r_state == ST_RD) || (r_state == ST_WR);
   assign w_words_inc = r_words + LW'(1);
   assign w_last      = (w_words_inc == r_len);
   assign w_dst_next  = r_dst + WORD_STEP;
   assign w_src_next  = r_src + WORD_STEP;

   // A job ends either on abort during an access phase or when the access
   // that completes the final word is accepted (copy reads never complete a word).
   assign w_finish = (w_active && i_abort) ||
                     (w_accept && w_last &&
                      ((r_state == ST_WR) || ((r_state == ST_RD) && (r_mode == MODE_CHECK))));

   // Job sequencer: state plus every registered output, so request outputs
   // stay stable while the controller holds off with ready low.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_mode     <= MODE_COPY;
         r_src      <= '0;
         r_dst      <= '0;
         r_len      <= '0;
         r_pattern  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
         r_words    <= '0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_be       <= 4'h0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_mode     <= i_mode;
                  r_src      <= i_src_addr;
                  r_dst      <= i_dst_addr;
                  r_len      <= i_len_words;
                  r_pattern  <= i_pattern;
                  r_err      <= 1'b0;
                  r_err_addr <= '0;
                  r_words    <= '0;
                  if (i_len_words == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else if (i_mode == MODE_RSVD) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_err      <= 1'b1;
                     r_err_addr <= i_dst_addr;
                  end else if (i_dst_addr[1:0] != 2'b00) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_err      <= 1'b1;
                     r_err_addr <= i_dst_addr;
                  end else if ((i_mode == MODE_COPY) && (i_src_addr[1:0] != 2'b00)) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_err      <= 1'b1;
                     r_err_addr <= i_src_addr;
                  end else begin
                     r_busy <= 1'b1;
                     r_req  <= 1'b1;
                     r_be   <= 4'hF;
                     if (i_mode == MODE_FILL) begin
                        r_state <= ST_WR;
                        r_we    <= 1'b1;
                        r_addr  <= i_dst_addr;
                        r_wdata <= i_pattern;
                     end else begin
                        r_state <= ST_RD;
                        r_we    <= 1'b0;
                        r_addr  <= (i_mode == MODE_COPY) ? i_src_addr : i_dst_addr;
                     end
                  end
               end
            end

            ST_RD: begin
               if (w_accept) begin
                  if (r_mode == MODE_COPY) begin
                     r_wdata <= i_sram_rdata;
                     r_state <= ST_WR;
                     r_we    <= 1'b1;
                     r_addr  <= r_dst;
                  end else begin
                     if ((i_sram_rdata != r_pattern) && !r_err) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_dst;
                     end
                     r_words <= w_words_inc;
                     r_dst   <= w_dst_next;
                     r_addr  <= w_dst_next;
                  end
               end
            end

            ST_WR: begin
               if (w_accept) begin
                  r_words <= w_words_inc;
                  r_dst   <= w_dst_next;
                  if (r_mode == MODE_COPY) begin
                     r_src   <= w_src_next;
                     r_state <= ST_RD;
                     r_we    <= 1'b0;
                     r_addr  <= w_src_next;
                  end else begin
                     r_addr  <= w_dst_next;
                  end
               end
            end

            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_finish) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
         end
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_err_addr   = r_err_addr;
   assign o_words_done = r_words;
   assign o_sram_req   = r_req;
   assign o_sram_we    = r_we;
   assign o_sram_be    = r_be;
   assign o_sram_addr  = r_addr;
   assign o_sram_wdata = r_wdata;

endmodule

// File: tb/tb_sram_dma_engine.sv
// tb_sram_dma_engine: drives sram_dma_engine against a behavioural SRAM with
// randomized ready stalls, and compares every job against a word-level model
// of copy/fill/check semantics (access order, final memory image, status).
module tb_sram_dma_engine;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int LW = 12;

   localparam logic [1:0] COPY  = 2'b00;
   localparam logic [1:0] FILL  = 2'b01;
   localparam logic [1:0] CHECK = 2'b10;

   typedef struct packed {
      logic        we;
      logic [12:0] addr;
      logic [31:0] data;
   } acc_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] srcAddr;
   logic [AW-1:0] dstAddr;
   logic [LW-1:0] lenWords;
   logic [DW-1:0] pattern;
   logic          abort;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] errAddr;
   logic [LW-1:0] wordsDone;
   logic          sramReq;
   logic          sramWe;
   logic [3:0]    sramBe;
   logic [AW-1:0] sramAddr;
   logic [DW-1:0] sramWdata;
   logic [DW-1:0] sramRdata;
   logic          sramReady;

   logic [31:0] mem    [2048];
   logic [31:0] refMem [2048];
   acc_t        expAcc [$];
   acc_t        obsAcc [$];
   logic        expErr;
   logic [12:0] expErrAddr;
   int          expWords;

   int checkCount = 0;
   int failCount  = 0;
   int readyPct   = 100;
   bit stabEn     = 1'b1;

   sram_dma_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_mode       (mode),
      .i_src_addr   (srcAddr),
      .i_dst_addr   (dstAddr),
      .i_len_words  (lenWords),
      .i_pattern    (pattern),
      .i_abort      (abort),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_err_addr   (errAddr),
      .o_words_done (wordsDone),
      .o_sram_req   (sramReq),
      .o_sram_we    (sramWe),
      .o_sram_be    (sramBe),
      .o_sram_addr  (sramAddr),
      .o_sram_wdata (sramWdata),
      .i_sram_rdata (sramRdata),
      .i_sram_ready (sramReady)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // The behavioural SRAM answers reads combinationally in the request cycle
   assign sramRdata = mem[sramAddr[12:2]];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic readyLoop();
      forever begin
         @(posedge clk);
         #1;
         sramReady = (int'($urandom_range(0, 99)) < readyPct);
      end
   endtask

   // Records accepted accesses, applies writes, and watches request stability
   task automatic monitorLoop();
      bit          prevPending = 1'b0;
      logic [12:0] prevAddr    = '0;
      logic        prevWe      = 1'b0;
      logic [31:0] prevWdata   = '0;
      acc_t        a;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checkOutput(sramReq ? "beActive" : "beIdle", 32'(sramBe), sramReq ? 32'hF : 32'h0);
            if (prevPending) begin
               checkOutput("holdReq",   32'(sramReq),   32'h1);
               checkOutput("holdAddr",  32'(sramAddr),  32'(prevAddr));
               checkOutput("holdWe",    32'(sramWe),    32'(prevWe));
               if (prevWe) checkOutput("holdWdata", sramWdata, prevWdata);
            end
            if (sramReq && sramReady) begin
               a.we   = sramWe;
               a.addr = sramAddr;
               a.data = sramWe ? sramWdata : mem[sramAddr[12:2]];
               obsAcc.push_back(a);
               if (sramWe) mem[sramAddr[12:2]] = sramWdata;
            end
            prevPending = stabEn && sramReq && !sramReady;
            prevAddr    = sramAddr;
            prevWe      = sramWe;
            prevWdata   = sramWdata;
         end else begin
            prevPending = 1'b0;
         end
      end
   endtask

   // Word-level reference: walks the job word by word on a copy of memory,
   // listing the accesses in issue order and stopping after 'limit' of them.
   task automatic modelJob(input logic [1:0] m, input logic [12:0] s0, input logic [12:0] d0,
                           input int len, input logic [31:0] pat, input int limit);
      acc_t        a;
      logic [12:0] s;
      logic [12:0] d;
      logic [31:0] v;
      int          i;
      refMem = mem;
      expAcc.delete();
      expErr     = 1'b0;
      expErrAddr = '0;
      expWords   = 0;
      if (len == 0) return;
      if (m == 2'b11 || d0[1:0] != 2'b00) begin
         expErr = 1'b1; expErrAddr = d0; return;
      end
      if (m == COPY && s0[1:0] != 2'b00) begin
         expErr = 1'b1; expErrAddr = s0; return;
      end
      i = 0;
      while (i < len && expAcc.size() < limit) begin
         s = s0 + 13'(i * 4);
         d = d0 + 13'(i * 4);
         if (m == FILL) begin
            a.we = 1'b1; a.addr = d; a.data = pat; expAcc.push_back(a);
            refMem[d[12:2]] = pat;
            expWords++;
         end else if (m == CHECK) begin
            v = refMem[d[12:2]];
            a.we = 1'b0; a.addr = d; a.data = v; expAcc.push_back(a);
            if (v != pat && !expErr) begin
               expErr = 1'b1; expErrAddr = d;
            end
            expWords++;
         end else begin
            v = refMem[s[12:2]];
            a.we = 1'b0; a.addr = s; a.data = v; expAcc.push_back(a);
            if (expAcc.size() < limit) begin
               a.we = 1'b1; a.addr = d; a.data = v; expAcc.push_back(a);
               refMem[d[12:2]] = v;
               expWords++;
            end
         end
         i++;
      end
   endtask

   task automatic runJob(input logic [1:0] m, input logic [12:0] s0, input logic [12:0] d0,
                         input int len, input logic [31:0] pat, input int pct,
                         input int abortAt, input bit pokeStart);
      int cyc;
      int n;
      int diffs;
      bit expActive;
      readyPct = pct;
      modelJob(m, s0, d0, len, pat, (abortAt > 0) ? abortAt : 32'h100000);
      expActive = (expAcc.size() > 0);
      obsAcc.delete();
      mode     = m;
      srcAddr  = s0;
      dstAddr  = d0;
      lenWords = LW'(len);
      pattern  = pat;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      checkOutput("busyFirst", 32'(busy),    32'(expActive));
      checkOutput("reqFirst",  32'(sramReq), 32'(expActive));
      while (!done && cyc < 5000) begin
         if (abortAt > 0 && cyc == abortAt) abort = 1'b1;
         if (pokeStart && cyc == 2) begin
            start   = 1'b1;
            mode    = COPY;
            pattern = ~pat;
         end
         tick();
         abort = 1'b0;
         start = 1'b0;
         cyc++;
      end
      checkOutput("doneSeen", 32'(done), 32'h1);
      if (pct == 100) checkOutput("jobCycles", 32'(cyc), 32'(expAcc.size() + 1));
      checkOutput("err",       32'(err),       32'(expErr));
      checkOutput("errAddr",   32'(errAddr),   32'(expErrAddr));
      checkOutput("wordsDone", 32'(wordsDone), 32'(expWords));
      checkOutput("busyAtDone", 32'(busy),    32'h0);
      checkOutput("reqAtDone",  32'(sramReq), 32'h0);
      checkOutput("accCount", 32'(obsAcc.size()), 32'(expAcc.size()));
      n = (obsAcc.size() < expAcc.size()) ? obsAcc.size() : expAcc.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("acc%0dWe", i),   32'(obsAcc[i].we),   32'(expAcc[i].we));
         checkOutput($sformatf("acc%0dAddr", i), 32'(obsAcc[i].addr), 32'(expAcc[i].addr));
         checkOutput($sformatf("acc%0dData", i), obsAcc[i].data,      expAcc[i].data);
      end
      diffs = 0;
      for (int i = 0; i < 2048; i++) if (mem[i] !== refMem[i]) diffs++;
      checkOutput("memImage", 32'(diffs), 32'h0);
      tick();
      checkOutput("donePulse", 32'(done), 32'h0);
   endtask

   task automatic applyStimulus();
      logic [1:0]  m;
      logic [12:0] d;
      logic [12:0] s;
      logic [31:0] pat;
      int          len;
      int          pct;
      int          r;
      for (int j = 0; j < 25; j++) begin
         r   = int'($urandom_range(0, 19));
         m   = (r < 7) ? FILL : (r < 14) ? COPY : (r < 19) ? CHECK : 2'b11;
         d   = 13'($urandom_range(0, 2047) * 4);
         s   = 13'($urandom_range(0, 2047) * 4);
         if ($urandom_range(0, 9) == 0) d[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) s[1:0] = 2'($urandom_range(1, 3));
         len = int'($urandom_range(0, 24));
         pat = $urandom;
         pct = ($urandom_range(0, 2) == 0) ? 100 : int'($urandom_range(30, 99));
         if (m == CHECK && $urandom_range(0, 1) == 1) begin
            for (int k = 0; k < len; k++) mem[(int'(d[12:2]) + k) % 2048] = pat;
            if (len > 0 && $urandom_range(0, 1) == 1)
               mem[(int'(d[12:2]) + int'($urandom_range(0, len - 1))) % 2048] ^= 32'h10;
         end
         runJob(m, s, d, len, pat, pct, 0, 1'b0);
      end
   endtask

   // Main sequence: reset, directed jobs, reset-during-job, then random jobs
   initial begin
      rst = 1'b1; start = 1'b0; mode = '0; srcAddr = '0; dstAddr = '0;
      lenWords = '0; pattern = '0; abort = 1'b0; sramReady = 1'b1;
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
      fork
         readyLoop();
         monitorLoop();
      join_none
      repeat (3) tick();
      checkOutput("rstBusy",   32'(busy),      32'h0);
      checkOutput("rstDone",   32'(done),      32'h0);
      checkOutput("rstErr",    32'(err),       32'h0);
      checkOutput("rstReq",    32'(sramReq),   32'h0);
      checkOutput("rstWe",     32'(sramWe),    32'h0);
      checkOutput("rstBe",     32'(sramBe),    32'h0);
      checkOutput("rstAddr",   32'(sramAddr),  32'h0);
      checkOutput("rstWdata",  sramWdata,      32'h0);
      checkOutput("rstErrA",   32'(errAddr),   32'h0);
      checkOutput("rstWords",  32'(wordsDone), 32'h0);
      rst = 1'b0;
      tick();

      runJob(FILL, 13'h0, 13'h0100, 4, 32'hA5A5A5A5, 100, 0, 1'b0);
      for (int k = 0; k < 4; k++) checkOutput("fillRead", mem[64 + k], 32'hA5A5A5A5);

      mem[0] = 32'hDEADBEEF; mem[1] = 32'hCAFEBABE; mem[2] = 32'h12345678;
      runJob(COPY, 13'h0, 13'h0800, 3, 32'h0, 100, 0, 1'b0);
      checkOutput("copyW0", mem[512], 32'hDEADBEEF);
      checkOutput("copyW1", mem[513], 32'hCAFEBABE);
      checkOutput("copyW2", mem[514], 32'h12345678);

      for (int k = 0; k < 4; k++) mem[128 + k] = 32'h0;
      mem[130] = 32'h1;
      runJob(CHECK, 13'h0, 13'h0200, 4, 32'h0, 100, 0, 1'b0);
      checkOutput("chkErrAddr", 32'(errAddr), 32'h0208);
      checkOutput("chkWords",   32'(wordsDone), 32'h4);

      runJob(FILL, 13'h0, 13'h1FF8, 3, 32'h5EED0001, 100, 0, 1'b0);
      checkOutput("wrap0", mem[2046], 32'h5EED0001);
      checkOutput("wrap1", mem[2047], 32'h5EED0001);
      checkOutput("wrap2", mem[0],    32'h5EED0001);

      runJob(2'b11, 13'h0, 13'h0100, 5, 32'h1, 100, 0, 1'b0);
      runJob(FILL, 13'h0, 13'h0102, 5, 32'h1, 100, 0, 1'b0);
      checkOutput("misalignErrA", 32'(errAddr), 32'h0102);
      runJob(COPY, 13'h0041, 13'h0100, 5, 32'h0, 100, 0, 1'b0);
      runJob(FILL, 13'h0, 13'h0300, 0, 32'h7, 100, 0, 1'b0);

      runJob(FILL, 13'h0, 13'h0300, 6, 32'h0BADF00D, 40, 0, 1'b1);
      runJob(FILL, 13'h0, 13'h0400, 10, 32'h3C3C3C3C, 100, 5, 1'b0);
      checkOutput("abortWords", 32'(wordsDone), 32'h5);
      runJob(COPY, 13'h0040, 13'h0600, 6, 32'h0, 100, 5, 1'b0);

      readyPct = 100;
      mode = COPY; srcAddr = 13'h0040; dstAddr = 13'h0A00; lenWords = LW'(8);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      stabEn = 1'b0;
      rst = 1'b1;
      tick();
      checkOutput("midRstReq",   32'(sramReq),   32'h0);
      checkOutput("midRstBusy",  32'(busy),      32'h0);
      checkOutput("midRstDone",  32'(done),      32'h0);
      checkOutput("midRstWe",    32'(sramWe),    32'h0);
      checkOutput("midRstBe",    32'(sramBe),    32'h0);
      checkOutput("midRstAddr",  32'(sramAddr),  32'h0);
      checkOutput("midRstWdata", sramWdata,      32'h0);
      checkOutput("midRstWords", 32'(wordsDone), 32'h0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("noDoneAfterRst", 32'(done), 32'h0);
      end
      stabEn = 1'b1;

      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("idleAbortDone", 32'(done), 32'h0);
      checkOutput("idleAbortBusy", 32'(busy), 32'h0);

      applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
